// File: rtl/int_trap_ctrl_pkg.sv
// XT_CSR: machine CSR addresses, mstatus/mip bit positions, interrupt cause
// codes and the trap-sequencer state encoding shared by int_trap_ctrl.
`default_nettype none

package XT_CSR;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  // Exception-code field of mcause; the interrupt flag is added separately.
  localparam logic [30:0] CAUSE_MSI = 31'd3;
  localparam logic [30:0] CAUSE_MTI = 31'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ENTER = 2'd2
  } trap_state_t;

endpackage

`default_nettype wire

// File: rtl/int_trap_ctrl_priority_sel.sv
// int_priority_sel: combines pending/enable lines with the global MIE and
// picks the highest-priority cause (external > software > timer).
`default_nettype none

module int_priority_sel
  import XT_CSR::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      pend_i,    // {ext, timer, soft}
  input  logic [2:0]      en_i,      // {ext, timer, soft}
  input  logic            glb_en_i,
  input  logic [30:0]     ext_id_i,
  output logic            take_o,
  output logic [XLEN-1:0] cause_o
);

  logic [2:0] act_w;

  always_comb begin
    act_w          = pend_i & en_i;
    take_o         = glb_en_i & (|act_w);
    cause_o        = '0;
    cause_o[XLEN-1] = 1'b1;
    if (act_w[2]) begin
      cause_o[30:0] = ext_id_i;
    end else if (act_w[0]) begin
      cause_o[30:0] = CAUSE_MSI;
    end else begin
      cause_o[30:0] = CAUSE_MTI;
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_trap_ctrl.sv
// int_trap_ctrl: machine-mode trap unit; owns mstatus/mie/mtvec/mepc/mcause,
// runs the trap request/ack handshake and issues fetch redirects.
`default_nettype none

module int_trap_ctrl
  import XT_CSR::*;
#(
  parameter int XLEN = 32
) (
  input  logic            hb_clk,
  input  logic            rst_sync_n,
  input  logic            mextern_int,
  input  logic [30:0]     mextern_int_id,
  input  logic            mtimer_int,
  input  logic            msoft_int,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            trap_req,
  input  logic            trap_ack,
  input  logic [XLEN-1:0] trap_epc,
  input  logic            mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_t     state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [2:0]      irq_en_q, irq_en_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mret_pend_q, mret_pend_d;

  logic [2:0]      pend_w;
  logic            take_w;
  logic [XLEN-1:0] sel_cause_w;
  logic            wr_mstatus_w, wr_mie_w, wr_mtvec_w, wr_mepc_w, wr_mcause_w;

  assign pend_w       = {mextern_int, mtimer_int, msoft_int};
  assign wr_mstatus_w = csr_we && (csr_addr == CSR_MSTATUS);
  assign wr_mie_w     = csr_we && (csr_addr == CSR_MIE);
  assign wr_mtvec_w   = csr_we && (csr_addr == CSR_MTVEC);
  assign wr_mepc_w    = csr_we && (csr_addr == CSR_MEPC);
  assign wr_mcause_w  = csr_we && (csr_addr == CSR_MCAUSE);

  int_priority_sel #(
    .XLEN (XLEN)
  ) u_prio (
    .pend_i   (pend_w),
    .en_i     (irq_en_q),
    .glb_en_i (mie_q),
    .ext_id_i (mextern_int_id),
    .take_o   (take_w),
    .cause_o  (sel_cause_w)
  );

  always_ff @(posedge hb_clk) begin
    if (!rst_sync_n) begin
      state_q     <= ST_IDLE;
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      irq_en_q    <= '0;
      mtvec_q     <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      cause_q     <= '0;
      epc_q       <= '0;
      mret_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      irq_en_q    <= irq_en_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      mret_pend_q <= mret_pend_d;
    end
  end

  // Software CSR writes first; sequencer actions below override them.
  always_comb begin
    state_d     = state_q;
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    irq_en_d    = irq_en_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    mret_pend_d = 1'b0;

    if (wr_mstatus_w) begin
      mie_d  = csr_wdata[MSTATUS_MIE];
      mpie_d = csr_wdata[MSTATUS_MPIE];
    end
    if (wr_mie_w) begin
      irq_en_d = {csr_wdata[IRQ_MEI], csr_wdata[IRQ_MTI], csr_wdata[IRQ_MSI]};
    end
    if (wr_mtvec_w) begin
      mtvec_d = csr_wdata & ALIGN_MASK;
    end
    if (wr_mepc_w) begin
      mepc_d = csr_wdata & ALIGN_MASK;
    end
    if (wr_mcause_w) begin
      mcause_d = csr_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (mret) begin
          mie_d       = mpie_q;
          mpie_d      = 1'b1;
          mret_pend_d = 1'b1;
        end else if (take_w) begin
          state_d = ST_REQ;
          cause_d = sel_cause_w;
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          state_d = ST_ENTER;
          epc_d   = trap_epc;
        end
      end
      ST_ENTER: begin
        mepc_d   = epc_q & ALIGN_MASK;
        mcause_d = cause_q;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign trap_req = (state_q == ST_REQ);

  // Gated by reset so a reset landing on ENTER never leaks a redirect.
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (state_q == ST_ENTER) begin
      redirect_valid = rst_sync_n;
      redirect_pc    = mtvec_q;
    end else if (mret_pend_q) begin
      redirect_valid = rst_sync_n;
      redirect_pc    = mepc_q;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[12:11]         = 2'b11;
        csr_rdata[MSTATUS_MPIE] = mpie_q;
        csr_rdata[MSTATUS_MIE]  = mie_q;
      end
      CSR_MIE: begin
        csr_rdata[IRQ_MEI] = irq_en_q[2];
        csr_rdata[IRQ_MTI] = irq_en_q[1];
        csr_rdata[IRQ_MSI] = irq_en_q[0];
      end
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MIP: begin
        csr_rdata[IRQ_MEI] = mextern_int;
        csr_rdata[IRQ_MTI] = mtimer_int;
        csr_rdata[IRQ_MSI] = msoft_int;
      end
      default: csr_rdata = '0;
    endcase
  end

endmodule

`default_nettype wire
